bg_theme_controller: RTL and testbench
======================================

# bg_theme_controller

Frame-rate sequencer that configures the background drawer's colors: holds the per-level color theme, runs a border/fill flash effect when the player is hit, and runs a blackout transition on level change. It sits between game logic (event pulses) and the background draw block, which consumes `fillRGB`/`borderRGB`/`bracketRGB` in place of its fixed colors. All timing is counted in frames via `startOfFrame`.

## Interface
- `FLASH_FRAMES`, 4: frames per flash phase (ON or OFF); ≥1
- `FLASH_COUNT`, 3: number of ON/OFF pairs per hit; ≥1
- `TRANS_FRAMES`, 60: frames of blackout on level change; ≥1

- `clk` in 1: system clock (pixel clock domain)
- `resetN` in 1: asynchronous, active-low reset
- `startOfFrame` in 1: one-cycle pulse at start of each frame
- `levelUp` in 1: one-cycle pulse, request level transition
- `playerHit` in 1: one-cycle pulse, request hit flash
- `fillRGB` out 8: background fill color, RRRGGGBB
- `borderRGB` out 8: outer border color
- `bracketRGB` out 8: inner bracket-line color
- `level` out 2: current level 0..3
- `busy` out 1: high in any state other than IDLE
- `transDone` out 1: one-cycle pulse when a transition completes

## Operation
- States: IDLE, FLASH_ON, FLASH_OFF, TRANS. Registers: state, `level` (2b), frameCnt (sized for max(FLASH_FRAMES, TRANS_FRAMES)), flashCnt.
- Level themes (fill): L0 8'b000_100_00, L1 8'b000_000_10, L2 8'b100_000_00, L3 8'b010_010_01.
- Per-state outputs:
  - IDLE / FLASH_OFF: fill = theme[level], border 8'b111_111_00, bracket 8'hFF.
  - FLASH_ON: fill 8'hFF, border 8'b111_000_00, bracket 8'hFF.
  - TRANS: fill 8'h00, border 8'b111_111_00, bracket 8'h00.
- Frame counting: frameCnt cleared on every state entry. On `startOfFrame`, if frameCnt == LIMIT-1 the phase ends; otherwise frameCnt increments. LIMIT is FLASH_FRAMES in FLASH_ON/FLASH_OFF and TRANS_FRAMES in TRANS.
- Transitions:
  - IDLE: `levelUp` → TRANS. Else `playerHit` → FLASH_ON with flashCnt=0.
  - FLASH_ON: phase end → FLASH_OFF.
  - FLASH_OFF: phase end → IDLE if flashCnt == FLASH_COUNT-1; else → FLASH_ON and flashCnt++.
  - FLASH_ON/FLASH_OFF + `levelUp` → TRANS, aborting the flash.
  - FLASH_ON/FLASH_OFF + `playerHit` (no `levelUp`) → FLASH_ON with flashCnt=0 and frameCnt=0 (restart).
  - TRANS: `levelUp` and `playerHit` are ignored. Phase end → IDLE, `level` ← `level`+1 (3 wraps to 0), `transDone` = 1 for that cycle.
- Simultaneous events: `levelUp` wins over `playerHit`. An event pulse coincident with a phase-end `startOfFrame` follows the event rule, not the phase-end rule.
- Events are not queued; a pulse that is ignored is lost.

## Timing
- All outputs are registered and decoded from the next state. Outputs change on the same clk edge that the state changes: 1 clock after the input pulse or phase-ending `startOfFrame`.
- Reset (async assert, any state including mid-TRANS or mid-flash):
  - state IDLE, `level` 0, frameCnt 0, flashCnt 0
  - `fillRGB` 8'b000_100_00, `borderRGB` 8'b111_111_00, `bracketRGB` 8'hFF
  - `busy` 0, `transDone` 0
- Flash duration: exactly 2·FLASH_FRAMES·FLASH_COUNT `startOfFrame` pulses after entry. Transition duration: exactly TRANS_FRAMES pulses.
- `transDone` is high for exactly one clock, on the edge where `level` updates and `busy` falls.
- `startOfFrame` in IDLE has no effect.

## Test plan
- Reset: drive resetN=0 mid-TRANS at level 2 → all outputs immediately equal the reset values above; `level`=0, `busy`=0.
- Hit flash (FLASH_FRAMES=2, FLASH_COUNT=2): `playerHit` → next edge fill 8'hFF, border 8'hE0. Over 8 frame pulses the sequence is ON,ON,OFF,OFF,ON,ON,OFF,OFF, then IDLE with fill 8'h10 and `busy`=0.
- Level change (TRANS_FRAMES=3): `levelUp` at L0 → fill and bracket 8'h00 for 3 frame pulses. Then `level`=1, fill 8'h02, one-clock `transDone`. Repeating from L3 gives `level`=0.
- Simultaneous `levelUp` and `playerHit` in IDLE → TRANS entered, no flash; `playerHit` during TRANS → no effect, duration unchanged.
- `levelUp` during FLASH_OFF → immediate TRANS. `playerHit` in 2nd ON phase → flash restarts and full length is counted from that point.
- Event pulse on the same cycle as a phase-ending `startOfFrame` → event rule applies (checked with `playerHit` in the last FLASH_OFF frame: flash restarts, not IDLE).

Source files
------------

// File: rtl/bg_theme_controller.sv
// Frame-rate background color sequencer: per-level theme, hit flash and level-change blackout.
// All outputs are registered and decoded from the next state, so they move on the same edge as the state.
module bg_theme_controller #(
  parameter int FLASH_FRAMES = 4,
  parameter int FLASH_COUNT  = 3,
  parameter int TRANS_FRAMES = 60
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       levelUp,
  input  logic       playerHit,
  output logic [7:0] fillRGB,
  output logic [7:0] borderRGB,
  output logic [7:0] bracketRGB,
  output logic [1:0] level,
  output logic       busy,
  output logic       transDone
);

  localparam int MAX_FRAMES = (FLASH_FRAMES > TRANS_FRAMES) ? FLASH_FRAMES : TRANS_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam int FLC_W      = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT) : 1;

  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_FRAMES - 1);
  localparam logic [CNT_W-1:0] TRANS_LAST = CNT_W'(TRANS_FRAMES - 1);
  localparam logic [FLC_W-1:0] PAIR_LAST  = FLC_W'(FLASH_COUNT - 1);

  localparam logic [7:0] BORDER_NORMAL = 8'b111_111_00;
  localparam logic [7:0] BORDER_HIT    = 8'b111_000_00;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLASH_ON  = 2'd1,
    FLASH_OFF = 2'd2,
    TRANS     = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] frame_cnt, frame_nx;
  logic [FLC_W-1:0] flash_cnt, flash_nx;
  logic [1:0]       level_nx;
  logic             done_nx;
  logic [7:0]       fill_nx, border_nx, bracket_nx;

  function automatic logic [7:0] theme(input logic [1:0] lvl);
    case (lvl)
      2'd0:    theme = 8'b000_100_00;
      2'd1:    theme = 8'b000_000_10;
      2'd2:    theme = 8'b100_000_00;
      default: theme = 8'b010_010_01;
    endcase
  endfunction

  // Event pulses are tested before the frame tick so a coincident event overrides a phase end.
  always_comb begin
    // NOTE: every variable gets a default first so no path can leave one unassigned and infer a latch.
    state_nx = state;
    frame_nx = frame_cnt;
    flash_nx = flash_cnt;
    level_nx = level;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (levelUp) begin
          state_nx = TRANS;
          frame_nx = '0;
        end else if (playerHit) begin
          state_nx = FLASH_ON;
          frame_nx = '0;
          flash_nx = '0;
        end
      end
      FLASH_ON, FLASH_OFF: begin
        if (levelUp) begin
          state_nx = TRANS;
          frame_nx = '0;
        end else if (playerHit) begin
          state_nx = FLASH_ON;
          frame_nx = '0;
          flash_nx = '0;
        end else if (startOfFrame) begin
          if (frame_cnt == FLASH_LAST) begin
            frame_nx = '0;
            if (state == FLASH_ON) begin
              state_nx = FLASH_OFF;
            end else if (flash_cnt == PAIR_LAST) begin
              state_nx = IDLE;
            end else begin
              state_nx = FLASH_ON;
              flash_nx = flash_cnt + FLC_W'(1);
            end
          end else begin
            frame_nx = frame_cnt + CNT_W'(1);
          end
        end
      end
      TRANS: begin
        if (startOfFrame) begin
          if (frame_cnt == TRANS_LAST) begin
            state_nx = IDLE;
            frame_nx = '0;
            level_nx = level + 2'd1;
            done_nx  = 1'b1;
          end else begin
            frame_nx = frame_cnt + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    fill_nx    = theme(level_nx);
    border_nx  = BORDER_NORMAL;
    bracket_nx = 8'hFF;
    case (state_nx)
      FLASH_ON: begin
        fill_nx   = 8'hFF;
        border_nx = BORDER_HIT;
      end
      TRANS: begin
        fill_nx    = 8'h00;
        bracket_nx = 8'h00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      flash_cnt  <= '0;
      level      <= 2'd0;
      fillRGB    <= 8'b000_100_00;
      borderRGB  <= BORDER_NORMAL;
      bracketRGB <= 8'hFF;
      busy       <= 1'b0;
      transDone  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the statement order.
      state      <= state_nx;
      frame_cnt  <= frame_nx;
      flash_cnt  <= flash_nx;
      level      <= level_nx;
      fillRGB    <= fill_nx;
      borderRGB  <= border_nx;
      bracketRGB <= bracket_nx;
      busy       <= (state_nx != IDLE);
      transDone  <= done_nx;
    end
  end

endmodule

// File: tb/tb_bg_theme_controller.sv
// Self-checking bench for bg_theme_controller: directed scenarios plus random pulses against
// an elapsed-frame reference model.
module tb_bg_theme_controller;

  localparam int FF = 2;
  localparam int FC = 2;
  localparam int TF = 3;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       levelUp = 1'b0;
  logic       playerHit = 1'b0;
  logic [7:0] fill, border, bracket;
  logic [1:0] level;
  logic       busy, trans_done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: activity kind plus total frames elapsed since the activity started.
  typedef enum int {M_IDLE, M_FLASH, M_TRANS} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_ticks = 0;
  int    m_level = 0;
  bit    m_done = 1'b0;
  logic [7:0] themes [4] = '{8'h10, 8'h02, 8'h80, 8'h49};

  bg_theme_controller #(
    .FLASH_FRAMES(FF),
    .FLASH_COUNT (FC),
    .TRANS_FRAMES(TF)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .levelUp     (levelUp),
    .playerHit   (playerHit),
    .fillRGB     (fill),
    .borderRGB   (border),
    .bracketRGB  (bracket),
    .level       (level),
    .busy        (busy),
    .transDone   (trans_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] expected();
    logic [7:0] f, b, k;
    f = themes[m_level];
    b = 8'hFC;
    k = 8'hFF;
    if (m_mode == M_FLASH && ((m_ticks / FF) % 2) == 0) begin
      f = 8'hFF;
      b = 8'hE0;
    end else if (m_mode == M_TRANS) begin
      f = 8'h00;
      k = 8'h00;
    end
    return {4'h0, f, b, k, 2'(m_level), (m_mode != M_IDLE), m_done};
  endfunction

  function automatic logic [31:0] observed();
    return {4'h0, fill, border, bracket, level, busy, trans_done};
  endfunction

  task automatic model_step(input bit lu, input bit ph, input bit sof);
    m_done = 1'b0;
    if (m_mode == M_TRANS) begin
      if (sof) begin
        m_ticks++;
        if (m_ticks == TF) begin
          m_mode  = M_IDLE;
          m_level = (m_level + 1) % 4;
          m_done  = 1'b1;
        end
      end
    end else if (lu) begin
      m_mode  = M_TRANS;
      m_ticks = 0;
    end else if (ph) begin
      m_mode  = M_FLASH;
      m_ticks = 0;
    end else if (m_mode == M_FLASH && sof) begin
      m_ticks++;
      if (m_ticks == 2 * FF * FC) m_mode = M_IDLE;
    end
  endtask

  task automatic cycle(input bit lu, input bit ph, input bit sof, input string tag);
    @(negedge clk);
    levelUp      = lu;
    playerHit    = ph;
    startOfFrame = sof;
    @(posedge clk);
    model_step(lu, ph, sof);
    #1 check(tag, observed(), expected());
  endtask

  task automatic frame(input string tag);
    cycle(1'b0, 1'b0, 1'b1, tag);
    cycle(1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    #12;
    check("reset_values", observed(), {4'h0, 8'h10, 8'hFC, 8'hFF, 2'd0, 1'b0, 1'b0});
    @(negedge clk);
    resetN = 1'b1;

    // Startup IDLE ignores frame pulses.
    frame("idle_frames");
    frame("idle_frames");

    // Full flash: ON,ON,OFF,OFF,ON,ON,OFF,OFF then IDLE.
    cycle(1'b0, 1'b1, 1'b0, "hit_entry");
    check("hit_fill_border", {16'h0, fill, border}, {16'h0, 8'hFF, 8'hE0});
    repeat (2 * FF * FC) frame("flash_seq");
    check("flash_end_idle", {23'h0, fill, busy}, {23'h0, 8'h10, 1'b0});

    // Level changes through all four levels, wrapping back to 0.
    for (int l = 0; l < 4; l++) begin
      cycle(1'b1, 1'b0, 1'b0, "trans_entry");
      repeat (TF - 1) frame("trans_body");
      cycle(1'b0, 1'b0, 1'b1, "trans_end");
      check("trans_done_level", {29'h0, level, trans_done}, {29'h0, 2'((l + 1) % 4), 1'b1});
      cycle(1'b0, 1'b0, 1'b0, "trans_done_drop");
    end

    // levelUp and playerHit together: transition wins; hits during TRANS are ignored.
    cycle(1'b1, 1'b1, 1'b0, "simul_events");
    cycle(1'b0, 1'b1, 1'b1, "hit_in_trans");
    cycle(1'b0, 1'b1, 1'b0, "hit_in_trans");
    repeat (TF - 1) frame("trans_with_hits");

    // levelUp in FLASH_OFF aborts into TRANS.
    cycle(1'b0, 1'b1, 1'b0, "hit2");
    repeat (FF) frame("to_off");
    cycle(1'b1, 1'b0, 1'b0, "lu_in_off");
    repeat (TF) frame("trans_after_abort");

    // Hit during 2nd ON phase restarts the whole flash.
    cycle(1'b0, 1'b1, 1'b0, "hit3");
    repeat (2 * FF + 1) frame("to_second_on");
    cycle(1'b0, 1'b1, 1'b0, "restart_in_on");
    repeat (2 * FF * FC) frame("restarted_flash");

    // Hit on the phase-ending frame of the last OFF: restarts instead of ending.
    cycle(1'b0, 1'b1, 1'b0, "hit4");
    repeat (2 * FF * FC - 1) frame("to_last_frame");
    cycle(1'b0, 1'b1, 1'b1, "hit_on_phase_end");
    check("restart_not_idle", {31'h0, busy}, 32'h1);
    repeat (2 * FF * FC) frame("flash_after_restart");

    // Random pulse traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 3) == 0, "random");
    end

    // Async reset mid-TRANS at level 2.
    resetN = 1'b0;
    #1;
    resetN = 1'b1;
    m_mode = M_IDLE; m_level = 0; m_ticks = 0; m_done = 1'b0;
    repeat (2) begin
      cycle(1'b1, 1'b0, 1'b0, "to_level2");
      repeat (TF) frame("to_level2");
    end
    cycle(1'b1, 1'b0, 1'b0, "trans_at_l2");
    frame("trans_at_l2");
    check("pre_reset_state", {29'h0, level, busy}, {29'h0, 2'd2, 1'b1});
    @(negedge clk);
    #2 resetN = 1'b0;
    #1 check("reset_mid_trans", observed(), {4'h0, 8'h10, 8'hFC, 8'hFF, 2'd0, 1'b0, 1'b0});
    m_mode = M_IDLE; m_level = 0; m_ticks = 0; m_done = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    frame("post_reset_idle");
    cycle(1'b0, 1'b1, 1'b0, "post_reset_hit");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
